// File: rtl/regfile_writeback_if.sv
// Writeback bus bundle: execute and load result handshakes in, register-file
// write port, pending-destination mask and FIFO occupancy out.
interface regfile_writeback_if #(
  parameter int DEPTH = 4
);
  logic                   exValid;
  logic                   exReady;
  logic [4:0]             exRd;
  logic [31:0]            exData;
  logic                   lsuValid;
  logic                   lsuReady;
  logic [4:0]             lsuRd;
  logic [31:0]            lsuData;
  logic                   writeEn;
  logic [4:0]             writeAddr;
  logic [31:0]            writeData;
  logic [31:0]            pendingMask;
  logic [$clog2(DEPTH):0] fifoCount;

  modport slave (
    input  exValid, exRd, exData, lsuValid, lsuRd, lsuData,
    output exReady, lsuReady, writeEn, writeAddr, writeData, pendingMask, fifoCount
  );

  modport master (
    output exValid, exRd, exData, lsuValid, lsuRd, lsuData,
    input  exReady, lsuReady, writeEn, writeAddr, writeData, pendingMask, fifoCount
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write front end: load results bypass, execute results queue in a FIFO.
// Optional load-vs-FIFO fairness is enabled with the WB_FAIRNESS_EN macro.
module regfile_writeback #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_writeback_if.slave    wb
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("regfile_writeback: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          r_wen;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;

  logic          w_full;
  logic          w_empty;
  logic          w_ex_acc;
  logic          w_lsu_ready;
  logic          w_lsu_acc;
  logic          w_deq;
  logic          w_sel_valid;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [31:0]   w_mask;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == (AW+1)'(0));
  assign w_ex_acc  = wb.exValid && !w_full;
  assign w_lsu_acc = wb.lsuValid && w_lsu_ready;
  assign w_deq     = !w_empty && !w_lsu_acc;

`ifdef WB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          w_starved;

  // A starved FIFO blocks the load port for one cycle so its head wins.
  assign w_starved   = !w_empty && (r_starve == SW'(STARVE_LIMIT));
  assign w_lsu_ready = !w_starved;

  // Starvation counter: counts consecutive cycles a non-empty FIFO loses to a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= SW'(0);
    end else if (w_empty || w_deq) begin
      r_starve <= SW'(0);
    end else if (w_lsu_acc) begin
      r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= r_starve;
    end
  end
`else
  assign w_lsu_ready = 1'b1;
`endif

  // Arbitration: accepted load first, then the FIFO head, else nothing.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = 5'd0;
    w_sel_data  = 32'd0;
    if (w_lsu_acc) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = wb.lsuRd;
      w_sel_data  = wb.lsuData;
    end else if (w_deq) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_rd[r_rptr];
      w_sel_data  = r_data[r_rptr];
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_ex_acc) begin
      r_rd[r_wptr]   <= wb.exRd;
      r_data[r_wptr] <= wb.exData;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW+1)'(0);
    end else begin
      r_wptr <= w_ex_acc ? r_wptr + AW'(1) : r_wptr;
      r_rptr <= w_deq    ? r_rptr + AW'(1) : r_rptr;
      case ({w_ex_acc, w_deq})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage; an x0 destination is consumed but produces no write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_sel_valid && (w_sel_rd != 5'd0)) begin
      r_wen   <= 1'b1;
      r_waddr <= w_sel_rd;
      r_wdata <= w_sel_data;
    end else begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end
  end

  // Pending mask: every valid FIFO slot plus the staged write; x0 is never pending.
  always_comb begin
    w_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_mask = w_mask | (({1'b0, AW'(i) - r_rptr} < r_count) ? (32'd1 << r_rd[i]) : 32'd0);
    end
    w_mask    = w_mask | (r_wen ? (32'd1 << r_waddr) : 32'd0);
    w_mask[0] = 1'b0;
  end

  assign wb.exReady     = !w_full;
  assign wb.lsuReady    = w_lsu_ready;
  assign wb.writeEn     = r_wen;
  assign wb.writeAddr   = r_waddr;
  assign wb.writeData   = r_wdata;
  assign wb.pendingMask = w_mask;
  assign wb.fifoCount   = r_count;

endmodule
